// File: rtl/cv32e40s_fencei_flush_responder.sv
// fence.i flush responder: drain stores, invalidate every line-buffer entry, pulse ack.
// Optional drain watchdog enabled by defining CV32E40S_FENCEI_FLUSH_TIMEOUT_EN.
module cv32e40s_fencei_flush_responder #(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = $clog2(NUM_LINES)
`ifdef CV32E40S_FENCEI_FLUSH_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fencei_flush_req_i,
  output logic             fencei_flush_ack_o,
  input  logic             store_busy_i,
  output logic             inv_valid_o,
  output logic [IDX_W-1:0] inv_idx_o,
  input  logic             inv_ready_i,
  output logic             flush_busy_o
`ifdef CV32E40S_FENCEI_FLUSH_TIMEOUT_EN
  ,
  output logic             flush_timeout_o
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DRAIN     = 3'd1,
    INVAL     = 3'd2,
    ACK       = 3'd3,
    WAIT_DROP = 3'd4
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [IDX_W-1:0] idx_q;
  logic             start;
  logic             inv_xfer;
  logic             last_idx;
  logic             drain_done;

  assign start    = (state_q == IDLE) && fencei_flush_req_i;
  assign inv_xfer = (state_q == INVAL) && inv_ready_i;
  assign last_idx = (idx_q == IDX_W'(NUM_LINES - 1));

`ifdef CV32E40S_FENCEI_FLUSH_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] wd_q;
  logic            wd_expired;
  logic            timeout_q;

  assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign drain_done = !store_busy_i || wd_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else if (start) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else if (state_q == DRAIN) begin
      wd_q <= wd_q + WD_W'(1);
      // Only a forced exit counts as a timeout; a drain finishing on the last cycle does not.
      if (store_busy_i && wd_expired) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign flush_timeout_o = timeout_q;
`else
  assign drain_done = !store_busy_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (fencei_flush_req_i) state_d = DRAIN;
      DRAIN:     if (drain_done) state_d = INVAL;
      INVAL:     if (inv_xfer && last_idx) state_d = ACK;
      ACK:       state_d = WAIT_DROP;
      // A req still held from the finished flush must not start a second one.
      WAIT_DROP: if (!fencei_flush_req_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Power-of-2 line count lets the index wrap to 0 naturally after the last line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (start) begin
      idx_q <= '0;
    end else if (inv_xfer) begin
      idx_q <= idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    fencei_flush_ack_o = (state_q == ACK);
    inv_valid_o        = (state_q == INVAL);
    inv_idx_o          = idx_q;
    flush_busy_o       = (state_q != IDLE);
  end

endmodule

// File: tb/tb_cv32e40s_fencei_flush_responder.sv
// Directed bench for cv32e40s_fencei_flush_responder; inputs driven and outputs sampled on negedge.
module tb_cv32e40s_fencei_flush_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req = 1'b0;
  logic       store_busy = 1'b0;
  logic       inv_ready = 1'b0;
  logic       ack;
  logic       inv_valid;
  logic [3:0] inv_idx;
  logic       busy;
`ifdef CV32E40S_FENCEI_FLUSH_TIMEOUT_EN
  logic       timeout;
`endif

  int total = 0;
  int bad   = 0;

  logic [3:0] pat = 4'b1001;  // ready sequence 1,0,0,1 by bit position

  always #5 clk = ~clk;

  cv32e40s_fencei_flush_responder #(
    .NUM_LINES(16)
`ifdef CV32E40S_FENCEI_FLUSH_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .fencei_flush_req_i (req),
    .fencei_flush_ack_o (ack),
    .store_busy_i       (store_busy),
    .inv_valid_o        (inv_valid),
    .inv_idx_o          (inv_idx),
    .inv_ready_i        (inv_ready),
    .flush_busy_o       (busy)
`ifdef CV32E40S_FENCEI_FLUSH_TIMEOUT_EN
    , .flush_timeout_o  (timeout)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int k;

    // Reset state
    #2 rst_n = 1'b0;
    step;
    step;
    chk("rst_ack", ack, 0);
    chk("rst_valid", inv_valid, 0);
    chk("rst_idx", inv_idx, 0);
    chk("rst_busy", busy, 0);
`ifdef CV32E40S_FENCEI_FLUSH_TIMEOUT_EN
    chk("rst_timeout", timeout, 0);
`endif
    rst_n = 1'b1;
    step;
    chk("idle_busy", busy, 0);

    // Basic flush: req in cycle 0, idx 0..15 in cycles 2..17, ack in 18, idle in 20
    req = 1'b1;
    inv_ready = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step;
      chk("t1_ack", ack, (c == 18));
      chk("t1_valid", inv_valid, (c >= 2 && c <= 17));
      if (c >= 2 && c <= 17) chk("t1_idx", inv_idx, c - 2);
      chk("t1_busy", busy, (c <= 19));
      if (c == 19) req = 1'b0;
    end

    // Drain stall: store busy through cycle 4; later busy during INVAL is ignored
    req = 1'b1;
    store_busy = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      step;
      chk("t2_ack", ack, (c == 22));
      chk("t2_valid", inv_valid, (c >= 6 && c <= 21));
      if (c >= 6 && c <= 21) chk("t2_idx", inv_idx, c - 6);
      chk("t2_busy", busy, (c <= 23));
      if (c == 5) store_busy = 1'b0;
      if (c == 8) store_busy = 1'b1;
      if (c == 12) store_busy = 1'b0;
      if (c == 23) req = 1'b0;
    end

    // Backpressure with ready 1,0,0,1 repeating
    req = 1'b1;
    step;
    chk("t3_drain_busy", busy, 1);
    chk("t3_drain_valid", inv_valid, 0);
    n = 0;
    k = 0;
    while (n < 16 && k < 100) begin
      step;
      chk("t3_valid", inv_valid, 1);
      chk("t3_idx", inv_idx, n);
      chk("t3_ack", ack, 0);
      inv_ready = pat[k % 4];
      if (inv_ready) n++;
      k++;
    end
    step;
    chk("t3_ack_pulse", ack, 1);
    chk("t3_ack_valid", inv_valid, 0);

    // Req held 3 cycles past ack: no second flush or ack
    for (int j = 1; j <= 3; j++) begin
      step;
      chk("t4_ack", ack, 0);
      chk("t4_valid", inv_valid, 0);
      chk("t4_busy", busy, 1);
      if (j == 3) req = 1'b0;
    end
    step;
    chk("t4_idle", busy, 0);
    req = 1'b1;
    step;
    chk("t4_drain_busy", busy, 1);
    chk("t4_drain_valid", inv_valid, 0);
    inv_ready = 1'b1;

    // Fresh flush from index 0, reset hits at index 7
    for (int i = 0; i <= 7; i++) begin
      step;
      chk("t4_valid", inv_valid, 1);
      chk("t4_idx", inv_idx, i);
    end
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", inv_valid, 0);
    chk("t5_rst_idx", inv_idx, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ack", ack, 0);
    step;
    chk("t5_rst_hold", busy, 0);
    rst_n = 1'b1;
    step;
    chk("t5_drain_busy", busy, 1);
    chk("t5_drain_valid", inv_valid, 0);
    for (int i = 0; i <= 15; i++) begin
      step;
      chk("t5_valid", inv_valid, 1);
      chk("t5_idx", inv_idx, i);
    end
    step;
    chk("t5_ack", ack, 1);
    req = 1'b0;
    step;
    chk("t5_wait_busy", busy, 1);
    chk("t5_ack_low", ack, 0);
    step;
    chk("t5_idle", busy, 0);

    // Early req deassertion: sequence still completes, WAIT_DROP exits at once
    req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step;
      if (c == 1) req = 1'b0;
      chk("t7_ack", ack, (c == 18));
      chk("t7_valid", inv_valid, (c >= 2 && c <= 17));
      if (c >= 2 && c <= 17) chk("t7_idx", inv_idx, c - 2);
      chk("t7_busy", busy, (c <= 19));
    end

`ifdef CV32E40S_FENCEI_FLUSH_TIMEOUT_EN
    // Watchdog: store busy stuck, INVAL after 8 DRAIN cycles, timeout sticky to next req
    req = 1'b1;
    store_busy = 1'b1;
    for (int c = 1; c <= 27; c++) begin
      step;
      chk("t6_valid", inv_valid, (c >= 9 && c <= 24));
      if (c >= 9 && c <= 24) chk("t6_idx", inv_idx, c - 9);
      chk("t6_ack", ack, (c == 25));
      chk("t6_timeout", timeout, (c >= 9));
      chk("t6_busy", busy, (c <= 26));
      if (c == 26) req = 1'b0;
    end
    store_busy = 1'b0;
    req = 1'b1;
    step;
    chk("t6_timeout_clr", timeout, 0);
    chk("t6_busy2", busy, 1);
    req = 1'b0;
    for (int c = 2; c <= 20; c++) step;
    chk("t6_final_idle", busy, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
